// File: rtl/ifsram_ld_if.sv
// Ifmap loader bundle: start/status, ifmap stream, column-buffer write port, pad handshake and tile config.
interface ifsram_ld_if #(
    parameter int TBITS   = 64,
    parameter int ADDBITS = 11
);
    logic               ld_start;
    logic               ld_busy;
    logic               ld_done;
    logic [TBITS-1:0]   s_data;
    logic               s_valid;
    logic               s_ready;
    logic [7:0]         buf_cen;
    logic [7:0]         buf_wen;
    logic [ADDBITS-1:0] buf_addr;
    logic [TBITS-1:0]   buf_data;
    logic               if_pad_start;
    logic               if_pad_done;
    logic [4:0]         cfg_atlchin;
    logic [2:0]         cfg_conv_switch;
    logic [2:0]         cfg_mast_state;
    logic [2:0]         cfg_rows_m1;
    logic [ADDBITS-1:0] cfg_row_stride;

    modport master (
        output ld_start, s_data, s_valid, if_pad_done,
               cfg_atlchin, cfg_conv_switch, cfg_mast_state, cfg_rows_m1, cfg_row_stride,
        input  ld_busy, ld_done, s_ready, buf_cen, buf_wen, buf_addr, buf_data, if_pad_start
    );

    modport slave (
        input  ld_start, s_data, s_valid, if_pad_done,
               cfg_atlchin, cfg_conv_switch, cfg_mast_state, cfg_rows_m1, cfg_row_stride,
        output ld_busy, ld_done, s_ready, buf_cen, buf_wen, buf_addr, buf_data, if_pad_start
    );
endinterface

// File: rtl/ifsram_ld.sv
// Ifmap tile loader: streams one tile into the column buffers, skipping pad-owned edge banks, then
// hands over to the padding sequencer.  IDLE | wait start; LOAD | accept beats; PADST | pad kick;
// PADWT | wait pad done; DONE | done pulse.
module ifsram_ld #(
    parameter int TBITS              = 64,
    parameter int IFMAP_SRAM_ADDBITS = 11,
    parameter int NUM_BUF            = 8
) (
    input  logic         clk,
    input  logic         reset,
    ifsram_ld_if.slave   bus
);
    localparam int AW = IFMAP_SRAM_ADDBITS;

    typedef enum logic [2:0] {IDLE, LOAD, PADST, PADWT, DONE} state_e;

    state_e              state_q, state_d;
    logic [4:0]          atl_q, atl_d, c_q, c_d;
    logic [2:0]          rows_q, rows_d, r_q, r_d, b_q, b_d;
    logic [2:0]          blo_q, blo_d, bhi_q, bhi_d;
    logic                pad_q, pad_d;
    logic [AW-1:0]       stride_q, stride_d, base_q, base_d, addr_q, addr_d;
    logic [NUM_BUF-1:0]  cen_q, cen_d;
    logic [TBITS-1:0]    data_q, data_d;
    logic [1:0]          p_cfg;
    logic [2:0]          lo_cfg, hi_cfg;
    logic                beat, last_c, last_b, last_r;

    // Pad count and writable bank window from the live config; only latched on ld_start.
    always_comb begin
        p_cfg  = 2'd0;
        lo_cfg = 3'd0;
        hi_cfg = 3'd7;
        if (bus.cfg_conv_switch == 3'd2) p_cfg = 2'd1;
        else if (bus.cfg_conv_switch == 3'd3) p_cfg = 2'd2;
        case (bus.cfg_mast_state)
            3'd1, 3'd7: lo_cfg = {1'b0, p_cfg};
            3'd3:       hi_cfg = 3'd7 - {1'b0, p_cfg};
            default:    p_cfg  = 2'd0;
        endcase
    end

    assign beat   = (state_q == LOAD) && bus.s_valid;
    assign last_c = (c_q == atl_q - 5'd1);
    assign last_b = (b_q == bhi_q);
    assign last_r = (r_q == rows_q);

    always_comb begin
        state_d  = state_q;
        atl_d    = atl_q;
        rows_d   = rows_q;
        stride_d = stride_q;
        blo_d    = blo_q;
        bhi_d    = bhi_q;
        pad_d    = pad_q;
        c_d      = c_q;
        b_d      = b_q;
        r_d      = r_q;
        base_d   = base_q;
        addr_d   = addr_q;
        data_d   = data_q;
        cen_d    = '1;
        case (state_q)
            IDLE: begin
                if (bus.ld_start) begin
                    state_d  = LOAD;
                    atl_d    = (bus.cfg_atlchin == 5'd0) ? 5'd1 : bus.cfg_atlchin;
                    rows_d   = bus.cfg_rows_m1;
                    stride_d = bus.cfg_row_stride;
                    blo_d    = lo_cfg;
                    bhi_d    = hi_cfg;
                    pad_d    = (p_cfg != 2'd0);
                    c_d      = 5'd0;
                    b_d      = lo_cfg;
                    r_d      = 3'd0;
                    base_d   = '0;
                end
            end
            LOAD: begin
                if (beat) begin
                    cen_d[b_q] = 1'b0;
                    addr_d     = base_q + AW'(c_q);
                    data_d     = bus.s_data;
                    if (last_c && last_b && last_r) begin
                        c_d     = 5'd0;
                        b_d     = 3'd0;
                        r_d     = 3'd0;
                        base_d  = '0;
                        state_d = pad_q ? PADST : DONE;
                    end else if (!last_c) begin
                        c_d = c_q + 5'd1;
                    end else begin
                        c_d = 5'd0;
                        if (!last_b) begin
                            b_d = b_q + 3'd1;
                        end else begin
                            b_d    = blo_q;
                            r_d    = r_q + 3'd1;
                            base_d = base_q + stride_q;
                        end
                    end
                end
            end
            PADST:   state_d = PADWT;
            PADWT:   if (bus.if_pad_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            atl_q    <= 5'd0;
            rows_q   <= 3'd0;
            stride_q <= '0;
            blo_q    <= 3'd0;
            bhi_q    <= 3'd0;
            pad_q    <= 1'b0;
            c_q      <= 5'd0;
            b_q      <= 3'd0;
            r_q      <= 3'd0;
            base_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            cen_q    <= '1;
        end else begin
            state_q  <= state_d;
            atl_q    <= atl_d;
            rows_q   <= rows_d;
            stride_q <= stride_d;
            blo_q    <= blo_d;
            bhi_q    <= bhi_d;
            pad_q    <= pad_d;
            c_q      <= c_d;
            b_q      <= b_d;
            r_q      <= r_d;
            base_q   <= base_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            cen_q    <= cen_d;
        end
    end

    assign bus.buf_cen      = cen_q;
    assign bus.buf_wen      = cen_q;
    assign bus.buf_addr     = addr_q;
    assign bus.buf_data     = data_q;
    assign bus.s_ready      = (state_q == LOAD);
    assign bus.ld_busy      = (state_q != IDLE);
    assign bus.ld_done      = (state_q == DONE);
    assign bus.if_pad_start = (state_q == PADST);
endmodule

// File: tb/tb_ifsram_ld.sv
// Directed tile loads with random data and valid gaps, checked against a loop-order model of the write sequence.
module tb_ifsram_ld;
    localparam int TB = 64;
    localparam int AW = 11;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ifsram_ld_if #(.TBITS(TB), .ADDBITS(AW)) bus ();

    ifsram_ld #(.TBITS(TB), .IFMAP_SRAM_ADDBITS(AW), .NUM_BUF(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cen"}, bus.buf_cen, 64'hFF);
        chk({tag, "_wen"}, bus.buf_wen, 64'hFF);
        chk({tag, "_busy"}, bus.ld_busy, 0);
        chk({tag, "_ready"}, bus.s_ready, 0);
        chk({tag, "_done"}, bus.ld_done, 0);
        chk({tag, "_padst"}, bus.if_pad_start, 0);
    endtask

    // One tile: ms/cs/atl/rows/stride config, vprob = % of cycles with s_valid,
    // hold = cycles before if_pad_done, poke = stray ld_start/if_pad_done mid-load,
    // abort_at = assert reset after that many writes (0 = never).
    task automatic run_tile(input int ms, input int cs, input int atl, input int rows,
                            input int stride, input int vprob, input int hold,
                            input bit poke, input int abort_at);
        int p, lo, hi, na, total, sent, got;
        bit pend, v;
        int eb[$];
        logic [AW-1:0] ea[$];
        logic [63:0] dq[$];
        logic [7:0] ecen;

        p = (cs == 2) ? 1 : (cs == 3) ? 2 : 0;
        if (!(ms == 1 || ms == 3 || ms == 7)) p = 0;
        lo = (ms == 3) ? 0 : p;
        hi = (ms == 3) ? 7 - p : 7;
        na = (atl == 0) ? 1 : atl;
        for (int r = 0; r <= rows; r++)
            for (int b = lo; b <= hi; b++)
                for (int c = 0; c < na; c++) begin
                    eb.push_back(b);
                    ea.push_back(AW'(r * stride + c));
                    dq.push_back({$urandom, $urandom});
                end
        total = eb.size();

        bus.cfg_mast_state  = 3'(ms);
        bus.cfg_conv_switch = 3'(cs);
        bus.cfg_atlchin     = 5'(atl);
        bus.cfg_rows_m1     = 3'(rows);
        bus.cfg_row_stride  = AW'(stride);
        bus.ld_start = 1'b1;
        @(negedge clk);
        bus.ld_start = 1'b0;
        bus.cfg_mast_state  = 3'($urandom);
        bus.cfg_conv_switch = 3'($urandom);
        bus.cfg_atlchin     = 5'($urandom);
        bus.cfg_rows_m1     = 3'($urandom);
        bus.cfg_row_stride  = AW'($urandom);
        chk("start_busy", bus.ld_busy, 1);

        sent = 0;
        got  = 0;
        pend = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (pend) begin
                ecen = ~(8'h01 << eb[got]);
                chk("wr_cen", bus.buf_cen, 64'(ecen));
                chk("wr_wen", bus.buf_wen, 64'(ecen));
                chk("wr_addr", bus.buf_addr, 64'(ea[got]));
                chk("wr_data", bus.buf_data, dq[got]);
                got++;
                pend = 1'b0;
                if (abort_at != 0 && got == abort_at) begin
                    #1 reset = 1'b1;
                    #1;
                    chk_idle("rst");
                    chk("rst_addr", bus.buf_addr, 0);
                    chk("rst_data", bus.buf_data, 0);
                    bus.s_valid = 1'b0;
                    @(negedge clk);
                    reset = 1'b0;
                    return;
                end
            end else begin
                chk("gap_cen", bus.buf_cen, 64'hFF);
            end
            if (got == total) break;
            chk("ready", bus.s_ready, 1);
            bus.ld_start    = 1'b0;
            bus.if_pad_done = 1'b0;
            if (poke && sent == 5) begin
                bus.ld_start    = 1'b1;
                bus.if_pad_done = 1'b1;
            end
            v = ($urandom_range(0, 99) < vprob);
            bus.s_valid = v;
            bus.s_data  = v ? dq[sent] : {$urandom, $urandom};
            if (v) begin
                sent++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        chk("beats", got, total);
        bus.ld_start    = 1'b0;
        bus.if_pad_done = 1'b0;
        bus.s_valid     = 1'b1;
        bus.s_data      = {$urandom, $urandom};

        chk("ready_drop", bus.s_ready, 0);
        if (p > 0) begin
            chk("pad_start", bus.if_pad_start, 1);
            chk("done_early", bus.ld_done, 0);
            @(negedge clk);
            chk("pad_start_once", bus.if_pad_start, 0);
            chk("padwt_busy", bus.ld_busy, 1);
            chk("padwt_cen", bus.buf_cen, 64'hFF);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_busy", bus.ld_busy, 1);
                chk("hold_done", bus.ld_done, 0);
                chk("hold_cen", bus.buf_cen, 64'hFF);
            end
            bus.if_pad_done = 1'b1;
            @(negedge clk);
            bus.if_pad_done = 1'b0;
            chk("done", bus.ld_done, 1);
        end else begin
            chk("done", bus.ld_done, 1);
            chk("no_pad_start", bus.if_pad_start, 0);
        end
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk_idle("end");
    endtask

    initial begin
        bus.ld_start        = 1'b0;
        bus.s_valid         = 1'b0;
        bus.s_data          = '0;
        bus.if_pad_done     = 1'b0;
        bus.cfg_atlchin     = '0;
        bus.cfg_conv_switch = '0;
        bus.cfg_mast_state  = '0;
        bus.cfg_rows_m1     = '0;
        bus.cfg_row_stride  = '0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_addr", bus.buf_addr, 0);
        chk("reset_data", bus.buf_data, 0);
        reset = 1'b0;
        @(negedge clk);

        run_tile(2, 2, 4, 2, 32, 100, 0, 1'b0, 0);
        run_tile(1, 3, 4, 4, int'($urandom_range(0, 2047)), 100, 20, 1'b0, 0);
        run_tile(3, 2, 2, 1, 100, 100, 0, 1'b0, 0);
        run_tile(2, 0, 4, 2, 32, 50, 0, 1'b0, 0);
        run_tile(2, 0, 4, 2, 32, 100, 0, 1'b0, 10);
        run_tile(2, 0, 4, 2, 32, 100, 0, 1'b0, 0);

        bus.if_pad_done = 1'b1;
        @(negedge clk);
        bus.if_pad_done = 1'b0;
        chk_idle("stray_done");
        run_tile(2, 0, 4, 2, 32, 100, 0, 1'b1, 0);

        run_tile(7, 2, 0, 7, 11'h7F0, 70, 3, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
